// File: rtl/burst_mem_device.sv
// burst_mem_device
//   Small register memory with burst access. A command in IDLE starts a
//   burst of burst_len+1 beats, one beat per cycle. The beat address
//   auto-increments from the sampled start address and wraps modulo the depth.
// Ports
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   address       burst start address, sampled with the command
//   burst_len     beats-1, sampled with the command
//   write_en      start a write burst (IDLE only)
//   read_en       start a read burst (IDLE only)
//   data_wr       write data, one word consumed per write beat
//   data_rd       registered read data, holds its value between read beats
//   rd_valid      data_rd carries a new read beat this cycle
//   busy          burst still in progress after its first beat
//   cmd_err       one-cycle pulse for an illegal or ignored command
module burst_mem_device #(
  parameter int ADDRESS_W = 4,
  parameter int DATA_W    = 8,
  parameter int BLEN_W    = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(8'hFF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRESS_W-1:0] address,
  input  logic [BLEN_W-1:0]    burst_len,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [DATA_W-1:0]    data_wr,
  output logic [DATA_W-1:0]    data_rd,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int DEPTH = 2**ADDRESS_W;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                 state, state_n;
  logic [BLEN_W-1:0]      cnt, cnt_n, len, len_n;
  logic [ADDRESS_W-1:0]   base, base_n;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic                   we, re, err_n;
  logic [ADDRESS_W-1:0]   waddr, raddr, beat_addr;

  // Beat address wraps naturally in ADDRESS_W bits.
  assign beat_addr = base + ADDRESS_W'(cnt);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    base_n  = base;
    we      = 1'b0;
    re      = 1'b0;
    waddr   = address;
    raddr   = address;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_en && read_en) begin
          err_n = 1'b1;
        end else if (write_en || read_en) begin
          // Beat 0 is served in the command cycle itself.
          we     = write_en;
          re     = read_en;
          base_n = address;
          len_n  = burst_len;
          if (burst_len != '0) begin
            state_n = write_en ? WR_BURST : RD_BURST;
            cnt_n   = BLEN_W'(1);
          end
        end
      end
      WR_BURST: begin
        we    = 1'b1;
        waddr = beat_addr;
        // write_en may stay asserted through a write burst; only a read is a conflict.
        err_n = read_en;
      end
      RD_BURST: begin
        re    = 1'b1;
        raddr = beat_addr;
        err_n = read_en | write_en;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE) begin
      if (cnt == len) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + BLEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      data_rd  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      len      <= len_n;
      base     <= base_n;
      rd_valid <= re;
      busy     <= (state_n != IDLE);
      cmd_err  <= err_n;
      if (re) data_rd <= mem[raddr];
      if (we) mem[waddr] <= data_wr;
    end
  end

endmodule
